// File: rtl/apb_master_fsm.sv
// Purpose : APB requester; runs one SETUP->ACCESS transfer per accepted command.
// Latency : cmd accepted at edge N -> SETUP N+1, ACCESS N+2.., rsp_valid in N+3 with a zero-wait slave.
// Backpr. : cmd_ready only in IDLE; rsp_valid is a one-cycle pulse with no backpressure.
//
// Ports:
//   PCLK, PRESETn                 clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_write, cmd_addr, cmd_wdata)
//   rsp_valid/rsp_rdata/rsp_err   completion pulse, read data (0 on write/error), error flag
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA, PRDATA/PREADY/PSLVERR   APB bus
//
// Optional build macro APB_MASTER_TIMEOUT_EN: aborts an ACCESS phase with rsp_err=1
// after TIMEOUT_CYCLES wait cycles with PREADY low. Without it ACCESS waits forever.
module apb_master_fsm #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  // The limit only matters in the timeout build; both builds keep one parameter set.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_cycles_unused
  end
`endif

  // Only cmd_ready is combinational, so a command can be accepted in the same
  // cycle the previous response pulse is seen (PSEL is already low there).
  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    paddr_d     = PADDR;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        // PREADY=1 takes priority over the timeout when both land in one cycle.
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!PWRITE && !PSLVERR) ? PRDATA : '0;
          state_d     = IDLE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th cycle with PREADY low: give up.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      PADDR     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      PADDR     <= paddr_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_apb_master_fsm.sv
// Purpose : self-checking bench for apb_master_fsm (table of transfers + corner sequences).
// Latency : drives inputs and samples outputs 1 time unit after each rising PCLK edge.
// Backpr. : plays the APB slave; PREADY/PSLVERR/PRDATA scripted per vector.
module tb_apb_master_fsm;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_master_fsm #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          slverr;
    logic [DW-1:0] prdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One complete transfer starting from IDLE; ends one cycle after the response pulse.
  task automatic run_xfer(input vec_t v);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    PREADY    = 1'b1;             // must be ignored outside ACCESS
    PSLVERR   = 1'b1;
    PRDATA    = 32'hFFFF_FFFF;
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_psel", PSEL, 1'b0);
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFF0;    // must not leak onto the bus
    cmd_wdata = ~v.wdata;
    cmd_write = ~v.wr;
    chk("setup_psel", PSEL, 1'b1);
    chk("setup_penable", PENABLE, 1'b0);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", PWRITE, v.wr);
    chk("setup_pwdata", PWDATA, v.wdata);
    chk("setup_cmd_ready", cmd_ready, 1'b0);
    tick();
    for (int i = 0; i <= v.waits; i++) begin
      chk("access_psel", PSEL, 1'b1);
      chk("access_penable", PENABLE, 1'b1);
      chk("access_paddr", PADDR, v.addr);
      chk("access_pwdata", PWDATA, v.wdata);
      chk("access_pwrite", PWRITE, v.wr);
      chk("access_rsp_valid", rsp_valid, 1'b0);
      chk("access_cmd_ready", cmd_ready, 1'b0);
      PREADY  = (i == v.waits);
      PSLVERR = (i == v.waits) ? v.slverr : 1'b1;
      PRDATA  = (i == v.waits) ? v.prdata : (32'hBAD0_0000 + 32'(i));
      tick();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    chk("done_rsp_valid", rsp_valid, 1'b1);
    chk("done_rsp_err", rsp_err, v.exp_err);
    chk("done_rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("done_psel", PSEL, 1'b0);
    chk("done_penable", PENABLE, 1'b0);
    chk("done_cmd_ready", cmd_ready, 1'b1);
    chk("done_paddr_hold", PADDR, v.addr);
    chk("done_pwdata_hold", PWDATA, v.wdata);
    tick();
    chk("post_rsp_valid", rsp_valid, 1'b0);
    chk("post_rsp_rdata_hold", rsp_rdata, v.exp_rdata);
    chk("post_rsp_err_hold", rsp_err, v.exp_err);
    chk("post_psel", PSEL, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // wr, addr, wdata, waits, slverr, prdata, exp_rdata, exp_err
    vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_5555, 32'h0,          1'b0};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         3, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0040, 32'h0,         0, 1'b1, 32'h0000_1234, 32'h0,          1'b1};
    vecs[3] = '{1'b1, 32'h0000_0010, 32'h0BAD_F00D, 2, 1'b1, 32'h7777_7777, 32'h0,          1'b1};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,         1, 1'b0, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0};

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    tick();
    tick();
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    #3 PRESETn = 1'b1;
    tick();

    // Table of single transfers.
    for (int n = 0; n < 5; n++) begin
      run_xfer(vecs[n]);
    end

    // cmd_valid held high for three back-to-back commands, zero-wait slave.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0020;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cmd_wdata = 32'h100 + 32'(k);
      chk("b2b_psel", PSEL, (k % 3 != 0));
      chk("b2b_penable", PENABLE, (k % 3 == 2));
      chk("b2b_cmd_ready", cmd_ready, (k % 3 == 0));
      chk("b2b_rsp_valid", rsp_valid, (k % 3 == 0) && (k > 0));
      if (k % 3 == 1) chk("b2b_pwdata", PWDATA, 32'h100 + 32'(k - 1));
      tick();
    end
    cmd_valid = 1'b0;
    chk("b2b_last_rsp", rsp_valid, 1'b1);
    chk("b2b_last_psel", PSEL, 1'b0);
    tick();
    chk("b2b_no_fourth", PSEL, 1'b0);
    chk("b2b_rsp_end", rsp_valid, 1'b0);
    PREADY = 1'b0;

    // Reset asserted in the middle of ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0044;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rstmid_in_access", PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rstmid_psel_async", PSEL, 1'b0);
    chk("rstmid_penable_async", PENABLE, 1'b0);
    chk("rstmid_cmd_ready", cmd_ready, 1'b1);
    PREADY = 1'b1;
    PRDATA = 32'hCAFE_0000;
    tick();
    tick();
    chk("rstmid_no_rsp", rsp_valid, 1'b0);
    #3 PRESETn = 1'b1;
    PREADY = 1'b0;
    tick();
    chk("rstmid_after_rsp", rsp_valid, 1'b0);
    chk("rstmid_after_psel", PSEL, 1'b0);
    chk("rstmid_after_paddr", PADDR, 32'h0);
    chk("rstmid_after_rdata", rsp_rdata, 32'h0);
    run_xfer(vecs[1]);

    // PREADY stuck low.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0080;
    PREADY    = 1'b0;
    PRDATA    = 32'h1111_1111;
    tick();
    cmd_valid = 1'b0;
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    begin
      int  acc  = 0;
      bit  seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (rsp_valid) begin
          seen = 1'b1;
        end else begin
          if (PENABLE) acc++;
          tick();
        end
      end
      chk("to_rsp_seen", seen, 1'b1);
      chk("to_wait_cycles", acc, TO);
      chk("to_rsp_err", rsp_err, 1'b1);
      chk("to_rsp_rdata", rsp_rdata, 32'h0);
      chk("to_psel", PSEL, 1'b0);
      chk("to_penable", PENABLE, 1'b0);
      tick();
      chk("to_rsp_end", rsp_valid, 1'b0);
    end
`else
    begin
      int pulses = 0;
      for (int i = 0; i < 40; i++) begin
        if (rsp_valid) pulses++;
        tick();
      end
      chk("stuck_no_rsp", pulses, 0);
      chk("stuck_psel", PSEL, 1'b1);
      chk("stuck_penable", PENABLE, 1'b1);
      PREADY = 1'b1;
      PRDATA = 32'h0000_0077;
      tick();
      PREADY = 1'b0;
      chk("stuck_release_rsp", rsp_valid, 1'b1);
      chk("stuck_release_rdata", rsp_rdata, 32'h0000_0077);
      chk("stuck_release_err", rsp_err, 1'b0);
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
